// File: rtl/ft245_sync_pkg.sv
// Shared types for the FT245 synchronous FIFO responder: bus ownership encoding and data width helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ft245_sync_pkg;

    typedef enum logic {
        BUS_FPGA = 1'b0,
        BUS_DEV  = 1'b1
    } bus_state_t;

    function automatic int FT_DATA_W(input int bw);
        return bw * 8;
    endfunction

endpackage

// File: rtl/ft245_resp_fifo.sv
// Synchronous first-word-fall-through FIFO; head is valid whenever empty=0.
// Latency: a pushed word is visible on head the cycle after the push edge.
// Backpressure: push ignored while full, pop ignored while empty; push+pop together keep the count.
module ft245_resp_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             aclk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge aclk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/ft245_sync_responder.sv
// Device-side FT245 sync FIFO responder: AXIS->RX FIFO->FT reads, FT writes->TX FIFO->AXIS. Optional sticky error flags with FT245_RESP_ERR_EN.
// Latency: one turnaround cycle per bus direction change; FWFT read data, writes visible on AXIS one cycle after the strobe edge.
// Backpressure: rxf_n/txe_n flags and AXIS tready/tvalid; reads when empty and writes when full or contended are dropped.
module ft245_sync_responder
    import ft245_sync_pkg::*;
#(
    parameter int bus_width = 1,
    parameter int RX_DEPTH  = 16,
    parameter int TX_DEPTH  = 16
) (
    input  logic                            aclk,
    input  logic                            rstn,
    output logic [FT_DATA_W(bus_width)-1:0] ft_data_o,
    input  logic [FT_DATA_W(bus_width)-1:0] ft_data_i,
    output logic                            ft_data_oe,
    output logic                            ft_rxf_n,
    output logic                            ft_txe_n,
    input  logic                            ft_oe_n,
    input  logic                            ft_rd_n,
    input  logic                            ft_wr_n,
    input  logic [FT_DATA_W(bus_width)-1:0] s_axis_tdata,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    output logic [FT_DATA_W(bus_width)-1:0] m_axis_tdata,
    output logic                            m_axis_tvalid,
`ifdef FT245_RESP_ERR_EN
    output logic                            err_wr_ovf,
    output logic                            err_rd_unf,
    output logic                            err_contend,
`endif
    input  logic                            m_axis_tready
);

    localparam int DW = FT_DATA_W(bus_width);

    bus_state_t state_q;
    bus_state_t state_d;
    logic       en;
    logic       rx_full;
    logic       rx_empty;
    logic       tx_full;
    logic       tx_empty;
    logic       rx_push;
    logic       rx_pop;
    logic       tx_push;
    logic       tx_pop;
    logic [DW-1:0] rx_head;

    always_ff @(posedge aclk or negedge rstn) begin
        if (!rstn) begin
            state_q <= BUS_FPGA;
            en      <= 1'b0;
        end else begin
            state_q <= state_d;
            en      <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BUS_FPGA: if (!ft_oe_n) state_d = BUS_DEV;
            BUS_DEV:  if (ft_oe_n)  state_d = BUS_FPGA;
            default:  state_d = BUS_FPGA;
        endcase
    end

    assign ft_data_oe = (state_q == BUS_DEV);
    assign ft_rxf_n   = ~en | rx_empty;
    assign ft_txe_n   = ~en | tx_full;
    assign ft_data_o  = rx_head;

    // Strobes only count once the bus has turned around to the matching direction.
    assign rx_pop  = ~ft_oe_n & ~ft_rd_n & ft_data_oe & ~rx_empty;
    assign tx_push = ~ft_wr_n & ~ft_data_oe & ~tx_full;

    assign s_axis_tready = en & ~rx_full;
    assign rx_push       = s_axis_tvalid & s_axis_tready;
    assign m_axis_tvalid = ~tx_empty;
    assign tx_pop        = m_axis_tvalid & m_axis_tready;

    ft245_resp_fifo #(.DEPTH(RX_DEPTH), .WIDTH(DW)) u_rx_fifo (
        .aclk     (aclk),
        .rstn     (rstn),
        .push     (rx_push),
        .push_dat (s_axis_tdata),
        .pop      (rx_pop),
        .head     (rx_head),
        .full     (rx_full),
        .empty    (rx_empty)
    );

    ft245_resp_fifo #(.DEPTH(TX_DEPTH), .WIDTH(DW)) u_tx_fifo (
        .aclk     (aclk),
        .rstn     (rstn),
        .push     (tx_push),
        .push_dat (ft_data_i),
        .pop      (tx_pop),
        .head     (m_axis_tdata),
        .full     (tx_full),
        .empty    (tx_empty)
    );

`ifdef FT245_RESP_ERR_EN
    always_ff @(posedge aclk or negedge rstn) begin
        if (!rstn) begin
            err_wr_ovf  <= 1'b0;
            err_rd_unf  <= 1'b0;
            err_contend <= 1'b0;
        end else begin
            if (~ft_wr_n & ~ft_data_oe & tx_full) err_wr_ovf  <= 1'b1;
            if (~ft_rd_n & ~ft_oe_n & rx_empty)   err_rd_unf  <= 1'b1;
            if (~ft_wr_n & ft_data_oe)            err_contend <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ft245_sync_responder.sv
// Bench for ft245_sync_responder: acts as FPGA master on the FT bus plus AXIS source/sink, scoreboarded through rx_q/tx_q.
module tb_ft245_sync_responder;

    logic       tb_data_clk = 1'b0;
    logic       rstn;
    logic [7:0] ft_data_o;
    logic [7:0] ft_data_i;
    logic       ft_data_oe;
    logic       ft_rxf_n;
    logic       ft_txe_n;
    logic       ft_oe_n;
    logic       ft_rd_n;
    logic       ft_wr_n;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tready;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
`ifdef FT245_RESP_ERR_EN
    logic       err_wr_ovf;
    logic       err_rd_unf;
    logic       err_contend;
`endif

    int errors = 0;
    int checks = 0;
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];

    always #5 tb_data_clk = ~tb_data_clk;

    ft245_sync_responder #(.bus_width(1), .RX_DEPTH(16), .TX_DEPTH(16)) dut (
        .aclk          (tb_data_clk),
        .rstn          (rstn),
        .ft_data_o     (ft_data_o),
        .ft_data_i     (ft_data_i),
        .ft_data_oe    (ft_data_oe),
        .ft_rxf_n      (ft_rxf_n),
        .ft_txe_n      (ft_txe_n),
        .ft_oe_n       (ft_oe_n),
        .ft_rd_n       (ft_rd_n),
        .ft_wr_n       (ft_wr_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
`ifdef FT245_RESP_ERR_EN
        .err_wr_ovf    (err_wr_ovf),
        .err_rd_unf    (err_rd_unf),
        .err_contend   (err_contend),
`endif
        .m_axis_tready (m_axis_tready)
    );

    task automatic tick();
        @(posedge tb_data_clk);
        #1;
    endtask

    task automatic axis_push(input logic [7:0] b);
        int n = 0;
        s_axis_tdata  = b;
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && n < 200) begin
            tick();
            n++;
        end
        if (!s_axis_tready) begin
            checks++;
            errors++;
            $display("FAIL axis_push_timeout: tready=%b required 1", s_axis_tready);
        end else begin
            rx_q.push_back(b);
            tick();
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick();
        tick();
        checks++; if (ft_rxf_n !== 1'b1)      begin errors++; $display("FAIL reset_rxf_n: got %b required 1", ft_rxf_n); end
        checks++; if (ft_txe_n !== 1'b1)      begin errors++; $display("FAIL reset_txe_n: got %b required 1", ft_txe_n); end
        checks++; if (ft_data_oe !== 1'b0)    begin errors++; $display("FAIL reset_oe: got %b required 0", ft_data_oe); end
        checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b required 0", s_axis_tready); end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b required 0", m_axis_tvalid); end
        rstn = 1'b1;
        #1;
        checks++; if (ft_txe_n !== 1'b1)      begin errors++; $display("FAIL release_txe_n_pre_edge: got %b required 1", ft_txe_n); end
        tick();
        checks++; if (ft_txe_n !== 1'b0)      begin errors++; $display("FAIL release_txe_n: got %b required 0", ft_txe_n); end
        checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL release_tready: got %b required 1", s_axis_tready); end
    endtask

    task automatic test_read();
        for (int i = 0; i < 4; i++) axis_push(8'(8'h41 + i));
        ft_oe_n = 1'b0;
        tick();
        checks++; if (ft_data_oe !== 1'b1) begin errors++; $display("FAIL read_turnaround_oe: got %b required 1", ft_data_oe); end
        for (int i = 0; i < 4; i++) begin
            ft_rd_n = 1'b0;
            checks++;
            if (rx_q.size() == 0 || ft_data_o !== rx_q[0]) begin
                errors++; $display("FAIL read_data[%0d]: got %h required %h", i, ft_data_o, rx_q.size() ? rx_q[0] : 8'hxx);
            end
            if (rx_q.size() != 0) void'(rx_q.pop_front());
            tick();
        end
        checks++; if (ft_rxf_n !== 1'b1) begin errors++; $display("FAIL read_rxf_n_after_4: got %b required 1", ft_rxf_n); end
        // One more strobe against an empty FIFO must be ignored.
        tick();
        checks++; if (ft_rxf_n !== 1'b1) begin errors++; $display("FAIL read_underflow_rxf_n: got %b required 1", ft_rxf_n); end
`ifdef FT245_RESP_ERR_EN
        checks++; if (err_rd_unf !== 1'b1) begin errors++; $display("FAIL err_rd_unf: got %b required 1", err_rd_unf); end
`endif
        ft_rd_n = 1'b1;
        ft_oe_n = 1'b1;
        tick();
        checks++; if (ft_data_oe !== 1'b0) begin errors++; $display("FAIL read_release_oe: got %b required 0", ft_data_oe); end
    endtask

    task automatic test_write_full();
        int cnt = 0;
        int n = 0;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            checks++;
            if (ft_txe_n !== (cnt >= 16)) begin
                errors++; $display("FAIL write_txe_n[%0d]: got %b required %b", i, ft_txe_n, cnt >= 16);
            end
            ft_data_i = 8'(8'h10 + i);
            ft_wr_n   = 1'b0;
            if (cnt < 16) begin
                tx_q.push_back(ft_data_i);
                cnt++;
            end
            tick();
        end
        ft_wr_n = 1'b1;
        checks++; if (ft_txe_n !== 1'b1)      begin errors++; $display("FAIL write_full_txe_n: got %b required 1", ft_txe_n); end
        checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL write_full_tvalid: got %b required 1", m_axis_tvalid); end
`ifdef FT245_RESP_ERR_EN
        checks++; if (err_wr_ovf !== 1'b1) begin errors++; $display("FAIL err_wr_ovf: got %b required 1", err_wr_ovf); end
`endif
        m_axis_tready = 1'b1;
        while (tx_q.size() != 0 && n < 100) begin
            if (m_axis_tvalid) begin
                checks++;
                if (m_axis_tdata !== tx_q[0]) begin
                    errors++; $display("FAIL write_drain_data: got %h required %h", m_axis_tdata, tx_q[0]);
                end
                void'(tx_q.pop_front());
            end
            tick();
            n++;
        end
        checks++; if (tx_q.size() != 0)       begin errors++; $display("FAIL write_drain_timeout: left %0d required 0", tx_q.size()); end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL write_drain_tvalid: got %b required 0 (0x20 must be dropped)", m_axis_tvalid); end
        m_axis_tready = 1'b0;
    endtask

    task automatic test_edge_push_pop();
        axis_push(8'h54);
        ft_oe_n = 1'b0;
        tick();
        checks++;
        if (rx_q.size() == 0 || ft_data_o !== rx_q[0]) begin
            errors++; $display("FAIL edge_head_54: got %h required 54", ft_data_o);
        end
        if (rx_q.size() != 0) void'(rx_q.pop_front());
        s_axis_tdata  = 8'h55;
        s_axis_tvalid = 1'b1;
        ft_rd_n       = 1'b0;
        rx_q.push_back(8'h55);
        tick();
        s_axis_tvalid = 1'b0;
        ft_rd_n       = 1'b1;
        checks++; if (ft_rxf_n !== 1'b0) begin errors++; $display("FAIL edge_rxf_n: got %b required 0", ft_rxf_n); end
        checks++;
        if (rx_q.size() == 0 || ft_data_o !== rx_q[0]) begin
            errors++; $display("FAIL edge_head_55: got %h required 55", ft_data_o);
        end
        if (rx_q.size() != 0) void'(rx_q.pop_front());
        ft_rd_n = 1'b0;
        tick();
        ft_rd_n = 1'b1;
        checks++; if (ft_rxf_n !== 1'b1) begin errors++; $display("FAIL edge_flush_rxf_n: got %b required 1", ft_rxf_n); end
        ft_oe_n = 1'b1;
        tick();
    endtask

    task automatic test_contention();
        ft_oe_n = 1'b0;
        tick();
        tick();
        ft_data_i = 8'hAA;
        ft_wr_n   = 1'b0;
        tick();
        ft_wr_n = 1'b1;
        tick();
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL contend_tvalid: got %b required 0", m_axis_tvalid); end
        checks++; if (ft_txe_n !== 1'b0)      begin errors++; $display("FAIL contend_txe_n: got %b required 0", ft_txe_n); end
`ifdef FT245_RESP_ERR_EN
        checks++; if (err_contend !== 1'b1) begin errors++; $display("FAIL err_contend: got %b required 1", err_contend); end
`endif
        ft_oe_n = 1'b1;
        tick();
    endtask

    task automatic test_loopback();
        logic [7:0] local_q[$];
        int got = 0;
        int rcv = 0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    axis_push(8'(8'h41 + i));
                    if ($urandom_range(0, 3) == 0) tick();
                end
            end
            begin
                int cyc = 0;
                while (got < 1000 && cyc < 20000) begin
                    ft_oe_n = 1'b0;
                    tick(); cyc++;
                    while (!ft_rxf_n && local_q.size() < 8) begin
                        ft_rd_n = 1'b0;
                        checks++;
                        if (rx_q.size() == 0 || ft_data_o !== rx_q[0]) begin
                            errors++; $display("FAIL loop_ft_read: got %h required %h", ft_data_o, rx_q.size() ? rx_q[0] : 8'hxx);
                        end
                        if (rx_q.size() != 0) void'(rx_q.pop_front());
                        local_q.push_back(ft_data_o);
                        got++;
                        tick(); cyc++;
                    end
                    ft_rd_n = 1'b1;
                    ft_oe_n = 1'b1;
                    tick(); cyc++;
                    while (local_q.size() != 0 && cyc < 20000) begin
                        if (!ft_txe_n) begin
                            ft_wr_n   = 1'b0;
                            ft_data_i = local_q.pop_front();
                            tx_q.push_back(ft_data_i);
                        end else begin
                            ft_wr_n = 1'b1;
                        end
                        tick(); cyc++;
                    end
                    ft_wr_n = 1'b1;
                end
            end
            begin
                int cyc = 0;
                while (rcv < 1000 && cyc < 25000) begin
                    m_axis_tready = ($urandom_range(0, 3) != 0);
                    if (m_axis_tready && m_axis_tvalid) begin
                        checks++;
                        if (tx_q.size() == 0 || m_axis_tdata !== tx_q[0] || m_axis_tdata !== 8'(8'h41 + rcv)) begin
                            errors++; $display("FAIL loop_axis_out[%0d]: got %h required %h", rcv, m_axis_tdata, 8'(8'h41 + rcv));
                        end
                        if (tx_q.size() != 0) void'(tx_q.pop_front());
                        rcv++;
                    end
                    tick(); cyc++;
                end
                m_axis_tready = 1'b0;
            end
        join
        checks++; if (got != 1000) begin errors++; $display("FAIL loop_read_count: got %0d required 1000", got); end
        checks++; if (rcv != 1000) begin errors++; $display("FAIL loop_recv_count: got %0d required 1000", rcv); end
    endtask

    initial begin
        rstn          = 1'b0;
        ft_data_i     = 8'h00;
        ft_oe_n       = 1'b1;
        ft_rd_n       = 1'b1;
        ft_wr_n       = 1'b1;
        s_axis_tdata  = 8'h00;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        test_reset();
        test_read();
        test_write_full();
        test_edge_push_pop();
        test_contention();
        test_loopback();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
